top_memwb: RTL and testbench



---
 rtl/mips_pkg.sv | 26 ++
 rtl/top_memwb_data_memory.sv | 27 ++
 rtl/top_memwb.sv | 130 +++++++++++++
 tb/tb_top_memwb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline control-field layout for the MIPS datapath.
// Used by top_IDEX (producer) and top_memwb (consumer) so both agree on
// which bit of the MEM/WB control bundles means what.
package mips_pkg;

   // Control-bundle widths and register-file index width
   localparam int MEM_W  = 3;
   localparam int WB_W   = 2;
   localparam int REG_AW = 5;

   // MEM bundle: {Branch, MemRead, MemWrite}
   localparam int MEM_BRANCH = 2;
   localparam int MEM_READ   = 1;
   localparam int MEM_WRITE  = 0;

   // WB bundle: {RegWrite, MemtoReg}
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   // A memory access whose byte address is not word aligned
   function automatic logic is_misaligned(input logic [1:0]       addr_lo,
                                          input logic [MEM_W-1:0] mem_ctl);
      return (mem_ctl[MEM_READ] | mem_ctl[MEM_WRITE]) & (addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/top_memwb_data_memory.sv
// Word-addressed data memory for the MEM stage: synchronous write,
// combinational (asynchronous) read, 2**DMEM_AW words of DATA_W bits.
module data_memory #(
   parameter int DMEM_AW = 8,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [DMEM_AW-1:0] i_addr,
   input  logic [DATA_W-1:0]  i_wdata,
   output logic [DATA_W-1:0]  o_rdata
);

   logic [DATA_W-1:0] r_mem [2**DMEM_AW];

   // Commit a store at the rising edge
   // NOTE: the array has no reset branch; clearing a RAM needs a write per
   // word, so contents simply persist across rst and start undefined.
   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_addr] <= i_wdata;
   end

   // Read sees the pre-edge contents, so a same-cycle write is not forwarded
   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/top_memwb.sv
// Back half of the pipeline: EX/MEM register, data-memory stage, branch
// resolution with wrong-path flush, MEM/WB register and writeback mux.
// Optional build macro: DMEM_ALIGN_CHECK_EN -- flags misaligned loads and
// stores, suppresses misaligned stores and blocks writeback of misaligned
// loads. Without it, address bits [1:0] are ignored and mem_misalign is 0.
module top_memwb
   import mips_pkg::*;
#(
   parameter int DMEM_AW = 8,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] baddr_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic              zero_in,
   input  logic [DATA_W-1:0] read_d2_in,
   input  logic [REG_AW-1:0] write_register_in,
   input  logic [MEM_W-1:0]  MEM_in,
   input  logic [WB_W-1:0]   WB_in,
   output logic              pcsrc,
   output logic [DATA_W-1:0] baddr_out,
   output logic              regwrite,
   output logic [REG_AW-1:0] write_register,
   output logic [DATA_W-1:0] write_data,
   output logic              mem_misalign
);

   // EX/MEM register
   logic [DATA_W-1:0] r_ex_baddr;
   logic [DATA_W-1:0] r_ex_result;
   logic              r_ex_zero;
   logic [DATA_W-1:0] r_ex_d2;
   logic [REG_AW-1:0] r_ex_wreg;
   logic [MEM_W-1:0]  r_ex_mem;
   logic [WB_W-1:0]   r_ex_wb;

   // MEM/WB register
   logic [WB_W-1:0]   r_wb_wb;
   logic [REG_AW-1:0] r_wb_wreg;
   logic [DATA_W-1:0] r_wb_result;
   logic [DATA_W-1:0] r_wb_rdata;

   logic              w_pcsrc;
   logic              w_misalign;
   logic              w_mem_we;
   logic [DATA_W-1:0] w_rdata;

   // Branch resolves from EX/MEM; a taken branch squashes the instruction
   // currently leaving EX by loading empty control bundles.
   assign w_pcsrc   = r_ex_mem[MEM_BRANCH] & r_ex_zero;
   assign pcsrc     = w_pcsrc;
   assign baddr_out = r_ex_baddr;

`ifdef DMEM_ALIGN_CHECK_EN
   logic r_wb_misalign;

   assign w_misalign = is_misaligned(r_ex_result[1:0], r_ex_mem);

   // Misalign flag travels with its instruction into the writeback cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wb_misalign <= 1'b0;
      else
         r_wb_misalign <= w_misalign;
   end

   assign mem_misalign = r_wb_misalign;
`else
   assign w_misalign   = 1'b0;
   assign mem_misalign = 1'b0;
`endif

   assign w_mem_we = r_ex_mem[MEM_WRITE] & ~w_misalign;

   data_memory #(
      .DMEM_AW (DMEM_AW),
      .DATA_W  (DATA_W)
   ) u_dmem (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_addr  (r_ex_result[DMEM_AW+1:2]),
      .i_wdata (r_ex_d2),
      .o_rdata (w_rdata)
   );

   // EX/MEM capture, with control bundles cleared when a branch is taken
   // NOTE: state is assigned with <= so every register samples pre-edge
   // values; blocking = here would let later statements see new values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_baddr  <= '0;
         r_ex_result <= '0;
         r_ex_zero   <= 1'b0;
         r_ex_d2     <= '0;
         r_ex_wreg   <= '0;
         r_ex_mem    <= '0;
         r_ex_wb     <= '0;
      end else begin
         r_ex_baddr  <= baddr_in;
         r_ex_result <= result_in;
         r_ex_zero   <= zero_in;
         r_ex_d2     <= read_d2_in;
         r_ex_wreg   <= write_register_in;
         r_ex_mem    <= w_pcsrc ? '0 : MEM_in;
         r_ex_wb     <= w_pcsrc ? '0 : WB_in;
      end
   end

   // MEM/WB capture; a misaligned load loses its register write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_wb     <= '0;
         r_wb_wreg   <= '0;
         r_wb_result <= '0;
         r_wb_rdata  <= '0;
      end else begin
         r_wb_wb[WB_REGWRITE] <= r_ex_wb[WB_REGWRITE] & ~(w_misalign & r_ex_mem[MEM_READ]);
         r_wb_wb[WB_MEMTOREG] <= r_ex_wb[WB_MEMTOREG];
         r_wb_wreg            <= r_ex_wreg;
         r_wb_result          <= r_ex_result;
         r_wb_rdata           <= w_rdata;
      end
   end

   assign regwrite       = r_wb_wb[WB_REGWRITE];
   assign write_register = r_wb_wreg;
   assign write_data     = r_wb_wb[WB_MEMTOREG] ? r_wb_rdata : r_wb_result;

endmodule

// File: tb/tb_top_memwb.sv
// Scoreboard bench for top_memwb: each issued instruction pushes its
// hand-computed branch and writeback expectations; a negedge monitor pops
// and compares them when the DUT presents that instruction's outputs.
module tb_top_memwb;

   logic        clk;
   logic        rst;
   logic [31:0] baddr_in;
   logic [31:0] result_in;
   logic        zero_in;
   logic [31:0] read_d2_in;
   logic [4:0]  write_register_in;
   logic [2:0]  MEM_in;
   logic [1:0]  WB_in;
   logic        pcsrc;
   logic [31:0] baddr_out;
   logic        regwrite;
   logic [4:0]  write_register;
   logic [31:0] write_data;
   logic        mem_misalign;

   top_memwb #(.DMEM_AW(8), .DATA_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .baddr_in          (baddr_in),
      .result_in         (result_in),
      .zero_in           (zero_in),
      .read_d2_in        (read_d2_in),
      .write_register_in (write_register_in),
      .MEM_in            (MEM_in),
      .WB_in             (WB_in),
      .pcsrc             (pcsrc),
      .baddr_out         (baddr_out),
      .regwrite          (regwrite),
      .write_register    (write_register),
      .write_data        (write_data),
      .mem_misalign      (mem_misalign)
   );

`ifdef DMEM_ALIGN_CHECK_EN
   localparam logic ALIGN = 1'b1;
`else
   localparam logic ALIGN = 1'b0;
`endif

   typedef struct {
      int          tag;
      logic        pcsrc;
      logic [31:0] baddr;
      logic        rw;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic        mis;
   } exp_t;

   exp_t q_br[$];
   exp_t q_wb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_cnt = 0;
   logic mon_en   = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one instruction after a rising edge and queue its expectations
   task automatic issue(input logic [31:0] baddr, input logic [31:0] res, input logic zero,
                        input logic [31:0] d2, input logic [4:0] wreg, input logic [2:0] mem,
                        input logic [1:0] wb, input logic e_pcsrc, input logic e_rw,
                        input logic [4:0] e_wreg, input logic [31:0] e_wdata, input logic e_mis);
      exp_t e;
      baddr_in          = baddr;
      result_in         = res;
      zero_in           = zero;
      read_d2_in        = d2;
      write_register_in = wreg;
      MEM_in            = mem;
      WB_in             = wb;
      e.tag   = edge_cnt + 1;
      e.pcsrc = e_pcsrc;
      e.baddr = baddr;
      e.rw    = e_rw;
      e.wreg  = e_wreg;
      e.wdata = e_wdata;
      e.mis   = e_mis;
      q_br.push_back(e);
      q_wb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      issue(32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
   endtask

   // Monitor: branch outputs one edge after capture, writeback two edges after
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && !rst) begin
         if (q_br.size() > 0 && q_br[0].tag == edge_cnt) begin
            e = q_br.pop_front();
            check($sformatf("pcsrc[%0d]", e.tag), {31'b0, pcsrc}, {31'b0, e.pcsrc});
            check($sformatf("baddr_out[%0d]", e.tag), baddr_out, e.baddr);
         end
         if (q_wb.size() > 0 && q_wb[0].tag + 1 == edge_cnt) begin
            e = q_wb.pop_front();
            check($sformatf("regwrite[%0d]", e.tag), {31'b0, regwrite}, {31'b0, e.rw});
            check($sformatf("write_register[%0d]", e.tag), {27'b0, write_register}, {27'b0, e.wreg});
            check($sformatf("write_data[%0d]", e.tag), write_data, e.wdata);
            check($sformatf("mem_misalign[%0d]", e.tag), {31'b0, mem_misalign}, {31'b0, e.mis});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      baddr_in = '0; result_in = '0; zero_in = 1'b0; read_d2_in = '0;
      write_register_in = '0; MEM_in = '0; WB_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset mid-operation with a register write and a taken branch in flight
      write_register_in = 5'd3; result_in = 32'h55; WB_in = 2'b10;
      @(posedge clk); #1;
      write_register_in = 5'd0; result_in = 32'h0; WB_in = 2'b00;
      MEM_in = 3'b100; zero_in = 1'b1; baddr_in = 32'h40;
      @(posedge clk); #2;
      check("pre_rst_regwrite", {31'b0, regwrite}, 32'd1);
      check("pre_rst_pcsrc", {31'b0, pcsrc}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_pcsrc", {31'b0, pcsrc}, 32'd0);
      check("rst_baddr_out", baddr_out, 32'd0);
      check("rst_regwrite", {31'b0, regwrite}, 32'd0);
      check("rst_write_register", {27'b0, write_register}, 32'd0);
      check("rst_write_data", write_data, 32'd0);
      check("rst_mem_misalign", {31'b0, mem_misalign}, 32'd0);
      baddr_in = '0; result_in = '0; zero_in = 1'b0; MEM_in = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;
      bubble();
      bubble();

      // ALU writeback
      issue(32'h0, 32'h2A, 1'b0, 32'h0, 5'd5, 3'b000, 2'b10, 1'b0, 1'b1, 5'd5, 32'h2A, 1'b0);
      // Store then back-to-back load of the same word
      issue(32'h0, 32'h10, 1'b0, 32'hDEADBEEF, 5'd0, 3'b001, 2'b00, 1'b0, 1'b0, 5'd0, 32'h10, 1'b0);
      issue(32'h0, 32'h10, 1'b0, 32'h0, 5'd8, 3'b010, 2'b11, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0);
      // Seed word 0x20, then a taken branch whose wrong-path store must vanish
      issue(32'h0, 32'h20, 1'b0, 32'hCAFEF00D, 5'd0, 3'b001, 2'b00, 1'b0, 1'b0, 5'd0, 32'h20, 1'b0);
      issue(32'h40, 32'h0, 1'b1, 32'h0, 5'd0, 3'b100, 2'b00, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      issue(32'h0, 32'h20, 1'b0, 32'h12345678, 5'd9, 3'b001, 2'b10, 1'b0, 1'b0, 5'd9, 32'h20, 1'b0);
      issue(32'h0, 32'h20, 1'b0, 32'h0, 5'd10, 3'b010, 2'b11, 1'b0, 1'b1, 5'd10, 32'hCAFEF00D, 1'b0);
      // Branch not taken; the next instruction completes
      issue(32'h80, 32'h0, 1'b0, 32'h0, 5'd0, 3'b100, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      issue(32'h0, 32'h33, 1'b0, 32'h0, 5'd7, 3'b000, 2'b10, 1'b0, 1'b1, 5'd7, 32'h33, 1'b0);
      // Address wrap: 0x400 aliases word 0
      issue(32'h0, 32'h400, 1'b0, 32'h0BADF00D, 5'd0, 3'b001, 2'b00, 1'b0, 1'b0, 5'd0, 32'h400, 1'b0);
      issue(32'h0, 32'h0, 1'b0, 32'h0, 5'd11, 3'b010, 2'b11, 1'b0, 1'b1, 5'd11, 32'h0BADF00D, 1'b0);
      // Read and write together: read sees the old word, later load sees the new
      issue(32'h0, 32'h30, 1'b0, 32'h11111111, 5'd0, 3'b001, 2'b00, 1'b0, 1'b0, 5'd0, 32'h30, 1'b0);
      issue(32'h0, 32'h30, 1'b0, 32'h22222222, 5'd12, 3'b011, 2'b11, 1'b0, 1'b1, 5'd12, 32'h11111111, 1'b0);
      issue(32'h0, 32'h30, 1'b0, 32'h0, 5'd14, 3'b010, 2'b11, 1'b0, 1'b1, 5'd14, 32'h22222222, 1'b0);
      // Misaligned store to 0x13 (word 4 holds 0xDEADBEEF), then reads of word 4
      issue(32'h0, 32'h13, 1'b0, 32'hFFFFFFFF, 5'd0, 3'b001, 2'b00, 1'b0, 1'b0, 5'd0, 32'h13, ALIGN);
      issue(32'h0, 32'h10, 1'b0, 32'h0, 5'd15, 3'b010, 2'b11, 1'b0, 1'b1, 5'd15,
            ALIGN ? 32'hDEADBEEF : 32'hFFFFFFFF, 1'b0);
      issue(32'h0, 32'h12, 1'b0, 32'h0, 5'd13, 3'b010, 2'b11, 1'b0, ~ALIGN, 5'd13,
            ALIGN ? 32'hDEADBEEF : 32'hFFFFFFFF, ALIGN);
      bubble();
      bubble();

      for (int i = 0; i < 10 && (q_br.size() + q_wb.size()) > 0; i++) @(posedge clk);
      @(negedge clk);
      check("queues_drained", q_br.size() + q_wb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
